pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 3-stage core. It consumes the hazard bubble count, CSR-write flag and valid bit produced by the decode/register-read stage, the execute-stage redirect, and the memory stall signals. It then drives fetch enable, decode hold, execute NOP injection and decode flush. It owns the multi-cycle stall counter, so a load-use hazard of N cycles produces exactly N injected NOPs. It also keeps a saturating hazard-stall performance counter.

---
 rtl/pipe_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl : sequencing controller for the 3-stage core.
//
// The block combines the decode hazard request, the execute redirect and the
// memory stalls into the per-cycle pipeline controls. It owns the multi-cycle
// hazard down-counter, so a load-use hazard of N cycles injects exactly N NOPs.
// It also keeps a saturating count of hazard/drain NOP cycles.
//
// Optional feature: define PIPE_CTRL_CSR_DRAIN_EN to stall a CSR write for
// DRAIN_CYCLES cycles before it issues. Without the macro, dec_csr_write is
// ignored and the DRAIN state is unreachable.
//
// Parameters:
//   DRAIN_CYCLES  stall cycles before a CSR write issues (1..3, drain only)
//   CNT_W         width of stall_count
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   dec_valid      decode holds a valid instruction
//   dec_bubble     NOPs requested by decode (0..2, 3 treated as 2)
//   dec_csr_write  decoded instruction is a CSR write
//   ex_redirect    execute resolved a taken branch/jump
//   mem_stall      data memory not ready, freeze the pipeline
//   imem_stall     instruction memory not ready
//   fetch_en       advance PC and capture the fetched instruction
//   dec_hold       decode register keeps its contents
//   ex_nop         execute input register loads a NOP
//   dec_flush      squash the instruction in decode
//   stall_count    saturating count of hazard/drain NOP cycles
//
// Outputs are combinational from the registered state and the current inputs;
// stall_count is the register itself.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             dec_valid,
   input  logic [1:0]       dec_bubble,
   input  logic             dec_csr_write,
   input  logic             ex_redirect,
   input  logic             mem_stall,
   input  logic             imem_stall,
   output logic             fetch_en,
   output logic             dec_hold,
   output logic             ex_nop,
   output logic             dec_flush,
   output logic [CNT_W-1:0] stall_count
);

   // Feature switch resolved to a constant so both builds share one datapath.
`ifdef PIPE_CTRL_CSR_DRAIN_EN
   localparam bit DRAIN_EN = 1'b1;
`else
   localparam bit DRAIN_EN = 1'b0;
`endif

   // Counter value loaded on the first drain cycle (that cycle is spent in RUN).
   localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HAZ   = 2'd1,
      ST_FILL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             csr_ok_q, csr_ok_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             nop_cycle;
   logic             haz_req;
   logic             drain_req;

   // Decode-side requests evaluated in RUN.
   assign haz_req   = dec_valid && (dec_bubble != 2'd0);
   assign drain_req = DRAIN_EN && dec_valid && dec_csr_write &&
                      (dec_bubble == 2'd0) && !csr_ok_q;

   // Next-state and output decode, highest priority first.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csr_ok_d  = csr_ok_q;
      fetch_en  = 1'b0;
      dec_hold  = 1'b0;
      ex_nop    = 1'b0;
      dec_flush = 1'b0;
      nop_cycle = 1'b0;

      if (!reset_n) begin
         // Register values are cleared by the sequential block.
         ex_nop    = 1'b1;
         dec_flush = 1'b1;
      end else if (mem_stall) begin
         // Full freeze; a redirect is re-asserted by the frozen execute stage.
         dec_hold = 1'b1;
      end else if (ex_redirect) begin
         fetch_en  = 1'b1;
         ex_nop    = 1'b1;
         dec_flush = 1'b1;
         cnt_d     = 2'd0;
         csr_ok_d  = 1'b0;
         state_d   = ST_FILL;
      end else begin
         unique case (state_q)
            ST_FILL: begin
               fetch_en = !imem_stall;
               ex_nop   = 1'b1;
               csr_ok_d = 1'b0;
               state_d  = ST_RUN;
            end
            ST_HAZ: begin
               dec_hold  = 1'b1;
               ex_nop    = 1'b1;
               nop_cycle = 1'b1;
               if (cnt_q <= 2'd1) begin
                  cnt_d   = 2'd0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            ST_DRAIN: begin
               // Exits on the cycle whose NOP completes DRAIN_CYCLES in total.
               dec_hold  = 1'b1;
               ex_nop    = 1'b1;
               nop_cycle = 1'b1;
               if (cnt_q <= 2'd1) begin
                  cnt_d    = 2'd0;
                  csr_ok_d = 1'b1;
                  state_d  = ST_RUN;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default: begin
               if (haz_req) begin
                  dec_hold  = 1'b1;
                  ex_nop    = 1'b1;
                  nop_cycle = 1'b1;
                  // Bubble 2 or 3 needs one further NOP from HAZ.
                  if (dec_bubble[1]) begin
                     cnt_d   = 2'd1;
                     state_d = ST_HAZ;
                  end
               end else if (drain_req) begin
                  dec_hold  = 1'b1;
                  ex_nop    = 1'b1;
                  nop_cycle = 1'b1;
                  if (DRAIN_CYCLES <= 1) begin
                     csr_ok_d = 1'b1;
                  end else begin
                     cnt_d   = DRAIN_LOAD;
                     state_d = ST_DRAIN;
                  end
               end else if (imem_stall) begin
                  csr_ok_d = 1'b0;
               end else begin
                  fetch_en = 1'b1;
                  csr_ok_d = 1'b0;
               end
            end
         endcase
      end

      // Saturating NOP counter; mem_stall and reset never reach nop_cycle.
      stall_count_d = stall_count_q;
      if (nop_cycle && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= 2'd0;
         csr_ok_q      <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         csr_ok_q      <= csr_ok_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl : directed, table-driven bench for pipe_ctrl.
// A default-width instance and a 4-bit-counter instance share all inputs.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic        clk;
   logic        reset_n;
   logic        dec_valid;
   logic [1:0]  dec_bubble;
   logic        dec_csr_write;
   logic        ex_redirect;
   logic        mem_stall;
   logic        imem_stall;
   logic        fetch_en, dec_hold, ex_nop, dec_flush;
   logic [31:0] stall_count;
   logic        fetch_en4, dec_hold4, ex_nop4, dec_flush4;
   logic [3:0]  stall_count4;

   int n_vec  = 0;
   int n_cmp  = 0;
   int n_miss = 0;

   pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid),
      .dec_bubble(dec_bubble), .dec_csr_write(dec_csr_write),
      .ex_redirect(ex_redirect), .mem_stall(mem_stall), .imem_stall(imem_stall),
      .fetch_en(fetch_en), .dec_hold(dec_hold), .ex_nop(ex_nop),
      .dec_flush(dec_flush), .stall_count(stall_count)
   );

   pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid),
      .dec_bubble(dec_bubble), .dec_csr_write(dec_csr_write),
      .ex_redirect(ex_redirect), .mem_stall(mem_stall), .imem_stall(imem_stall),
      .fetch_en(fetch_en4), .dec_hold(dec_hold4), .ex_nop(ex_nop4),
      .dec_flush(dec_flush4), .stall_count(stall_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst_n;
      logic        valid;
      logic [1:0]  bubble;
      logic        csr;
      logic        redir;
      logic        mstall;
      logic        istall;
      logic        f;
      logic        h;
      logic        n;
      logic        l;
      logic [31:0] cnt;
   } vec_t;

   localparam int NV = 35;
   vec_t tbl [NV];

   function automatic vec_t mkv(input logic r, input logic v, input logic [1:0] b,
                                input logic c, input logic x, input logic m,
                                input logic i, input logic f, input logic h,
                                input logic n, input logic l, input int unsigned cnt);
      vec_t t;
      t.rst_n = r;  t.valid = v; t.bubble = b; t.csr = c; t.redir = x;
      t.mstall = m; t.istall = i; t.f = f; t.h = h; t.n = n; t.l = l;
      t.cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   task automatic drive(input vec_t t);
      @(negedge clk);
      reset_n       = t.rst_n;
      dec_valid     = t.valid;
      dec_bubble    = t.bubble;
      dec_csr_write = t.csr;
      ex_redirect   = t.redir;
      mem_stall     = t.mstall;
      imem_stall    = t.istall;
      #1;
   endtask

   task automatic apply(input vec_t t, input string name);
      logic [31:0] want4;
      drive(t);
      n_vec++;
      want4 = (t.cnt > 32'd15) ? 32'd15 : t.cnt;
      chk({name, ".fetch_en"},    32'(fetch_en),     32'(t.f));
      chk({name, ".dec_hold"},    32'(dec_hold),     32'(t.h));
      chk({name, ".ex_nop"},      32'(ex_nop),       32'(t.n));
      chk({name, ".dec_flush"},   32'(dec_flush),    32'(t.l));
      chk({name, ".stall_count"}, stall_count,       t.cnt);
      chk({name, ".stall_cnt4"},  32'(stall_count4), want4);
   endtask

   initial begin
      reset_n = 1'b0; dec_valid = 1'b0; dec_bubble = 2'd0; dec_csr_write = 1'b0;
      ex_redirect = 1'b0; mem_stall = 1'b0; imem_stall = 1'b0;

      //                 r  v  b    c  x  m  i    F  H  N  L  cnt
      tbl[0]  = mkv(0, 0, 2'd0, 0, 0, 0, 0,  0, 0, 1, 1, 0); // reset
      tbl[1]  = mkv(0, 1, 2'd2, 0, 0, 0, 0,  0, 0, 1, 1, 0); // reset beats hazard
      tbl[2]  = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0); // normal
      tbl[3]  = mkv(1, 1, 2'd2, 0, 0, 0, 0,  0, 1, 1, 0, 0); // bubble 2, NOP 1
      tbl[4]  = mkv(1, 1, 2'd1, 0, 0, 0, 0,  0, 1, 1, 0, 1); // HAZ, NOP 2
      tbl[5]  = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 2); // issue
      tbl[6]  = mkv(1, 1, 2'd2, 0, 0, 0, 0,  0, 1, 1, 0, 2); // bubble 2
      tbl[7]  = mkv(1, 1, 2'd0, 0, 0, 1, 0,  0, 1, 0, 0, 3); // mem_stall in HAZ
      tbl[8]  = mkv(1, 1, 2'd0, 0, 0, 1, 0,  0, 1, 0, 0, 3);
      tbl[9]  = mkv(1, 1, 2'd0, 0, 1, 1, 0,  0, 1, 0, 0, 3); // redirect ignored
      tbl[10] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  0, 1, 1, 0, 3); // HAZ resumes
      tbl[11] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 4);
      tbl[12] = mkv(1, 1, 2'd2, 0, 0, 0, 0,  0, 1, 1, 0, 4); // bubble 2
      tbl[13] = mkv(1, 1, 2'd2, 0, 1, 0, 0,  1, 0, 1, 1, 5); // redirect in HAZ
      tbl[14] = mkv(1, 1, 2'd2, 0, 0, 0, 1,  0, 0, 1, 0, 5); // FILL, imem_stall
      tbl[15] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 5);
      tbl[16] = mkv(1, 1, 2'd2, 0, 1, 0, 0,  1, 0, 1, 1, 5); // redirect + bubble
      tbl[17] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 1, 0, 5); // FILL
      tbl[18] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 5);
      tbl[19] = mkv(1, 1, 2'd3, 0, 0, 0, 0,  0, 1, 1, 0, 5); // bubble 3 as 2
      tbl[20] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  0, 1, 1, 0, 6);
      tbl[21] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 7);
      tbl[22] = mkv(1, 0, 2'd2, 0, 0, 0, 0,  1, 0, 0, 0, 7); // invalid decode
      tbl[23] = mkv(1, 1, 2'd0, 0, 0, 0, 1,  0, 0, 0, 0, 7); // imem_stall
      tbl[24] = mkv(1, 1, 2'd1, 0, 0, 0, 1,  0, 1, 1, 0, 7); // hazard > imem
      tbl[25] = mkv(1, 1, 2'd2, 0, 0, 0, 0,  0, 1, 1, 0, 8); // bubble 2
      tbl[26] = mkv(0, 1, 2'd0, 0, 0, 0, 0,  0, 0, 1, 1, 9); // reset mid-HAZ
      tbl[27] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0); // RUN, cleared
      tbl[28] = mkv(1, 1, 2'd0, 0, 0, 1, 0,  0, 1, 0, 0, 0); // mem_stall in RUN
      tbl[29] = mkv(1, 1, 2'd0, 0, 1, 0, 1,  1, 0, 1, 1, 0); // redirect + imem
      tbl[30] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 1, 0, 0); // FILL
      tbl[31] = mkv(1, 1, 2'd0, 0, 1, 0, 0,  1, 0, 1, 1, 0); // redirect
      tbl[32] = mkv(1, 1, 2'd0, 0, 0, 1, 0,  0, 1, 0, 0, 0); // mem_stall in FILL
      tbl[33] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 1, 0, 0); // FILL resumes
      tbl[34] = mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0);

      for (int k = 0; k < NV; k++) apply(tbl[k], $sformatf("vec%0d", k));

      // CSR write in decode from RUN with csr_ok clear.
`ifdef PIPE_CTRL_CSR_DRAIN_EN
      apply(mkv(1, 1, 2'd0, 1, 0, 0, 0,  0, 1, 1, 0, 0), "csr0");
      apply(mkv(1, 1, 2'd0, 1, 0, 0, 0,  0, 1, 1, 0, 1), "csr1");
      apply(mkv(1, 1, 2'd0, 1, 0, 0, 0,  1, 0, 0, 0, 2), "csr_issue");
      apply(mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 2), "csr_after");
`else
      apply(mkv(1, 1, 2'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0), "csr0");
      apply(mkv(1, 1, 2'd0, 1, 0, 0, 0,  1, 0, 0, 0, 0), "csr1");
      apply(mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 0), "csr_after");
`endif

      // Saturation: 20 single-bubble hazards from a fresh reset.
      drive(mkv(0, 0, 2'd0, 0, 0, 0, 0,  0, 0, 1, 1, 0));
      for (int k = 0; k < 20; k++) begin
         apply(mkv(1, 1, 2'd1, 0, 0, 0, 0,  0, 1, 1, 0, 32'(k)), $sformatf("sat%0d", k));
      end
      apply(mkv(1, 1, 2'd0, 0, 0, 0, 0,  1, 0, 0, 0, 20), "sat_hold");
      apply(mkv(1, 1, 2'd0, 0, 1, 0, 0,  1, 0, 1, 1, 20), "sat_redir");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
